// File: rtl/mem_access.sv
// MIPS MEM stage: runs the data-bus req/ack transaction for loads/stores and registers the MEM/WB triple.
// Latency 1 cycle for non-memory ops, 2+N for memory ops; stall_o holds the upstream pipe while BUSY.
module mem_access #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [4:0]  mem_waddr_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_sdata_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        stall_o,
    output logic [31:0] wb_wdata_o,
    output logic [4:0]  wb_waddr_o,
    output logic        wb_we_o,
    output logic        misalign_o,
    output logic        bus_err_o
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [7:0] TO_LAST = 8'(BUS_TIMEOUT - 1);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_req, w_req_nxt;
    logic        r_dwe, w_dwe_nxt;
    logic [31:0] r_daddr, w_daddr_nxt;
    logic [3:0]  r_be, w_be_nxt;
    logic [31:0] r_dwdata, w_dwdata_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [3:0]  r_op, w_op_nxt;
    logic [1:0]  r_off, w_off_nxt;
    logic [4:0]  r_hwaddr, w_hwaddr_nxt;
    logic        r_hwe, w_hwe_nxt;
    logic [31:0] r_wb_wdata, w_wb_wdata_nxt;
    logic [4:0]  r_wb_waddr, w_wb_waddr_nxt;
    logic        r_wb_we, w_wb_we_nxt;
    logic        r_misal, w_misal_nxt;
    logic        r_err, w_err_nxt;

    logic        w_is_load, w_is_store, w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_sdata_rep;
    logic [31:0] w_lane, w_load_data;

    always_comb begin
        w_is_load   = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LW);
        w_is_store  = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
        w_misalign  = 1'b0;
        w_be        = 4'b1111;
        w_sdata_rep = mem_sdata_i;
        case (mem_op_i)
            OP_LH, OP_LHU: w_misalign = mem_addr_i[0];
            OP_LW, OP_SW:  w_misalign = |mem_addr_i[1:0];
            OP_SB: begin
                w_be        = 4'b0001 << mem_addr_i[1:0];
                w_sdata_rep = {4{mem_sdata_i[7:0]}};
            end
            OP_SH: begin
                w_misalign  = mem_addr_i[0];
                w_be        = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                w_sdata_rep = {2{mem_sdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Shift the addressed lane down to bit 0; halfword offsets are always 0 or 2 here.
    always_comb begin
        w_lane = dbus_rdata_i >> {r_off, 3'b000};
        case (r_op)
            OP_LB:   w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
            OP_LBU:  w_load_data = {24'b0, w_lane[7:0]};
            OP_LH:   w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
            OP_LHU:  w_load_data = {16'b0, w_lane[15:0]};
            default: w_load_data = dbus_rdata_i;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_req;
        w_dwe_nxt      = r_dwe;
        w_daddr_nxt    = r_daddr;
        w_be_nxt       = r_be;
        w_dwdata_nxt   = r_dwdata;
        w_cnt_nxt      = r_cnt;
        w_op_nxt       = r_op;
        w_off_nxt      = r_off;
        w_hwaddr_nxt   = r_hwaddr;
        w_hwe_nxt      = r_hwe;
        w_wb_wdata_nxt = r_wb_wdata;
        w_wb_waddr_nxt = r_wb_waddr;
        w_wb_we_nxt    = 1'b0;
        w_misal_nxt    = 1'b0;
        w_err_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_valid_i) begin
                    if (!(w_is_load || w_is_store)) begin
                        w_wb_wdata_nxt = mem_wdata_i;
                        w_wb_waddr_nxt = mem_waddr_i;
                        w_wb_we_nxt    = mem_we_i;
                    end else if (w_misalign) begin
                        w_misal_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = ST_BUSY;
                        w_req_nxt    = 1'b1;
                        w_dwe_nxt    = w_is_store;
                        w_daddr_nxt  = {mem_addr_i[31:2], 2'b00};
                        w_be_nxt     = w_be;
                        w_dwdata_nxt = w_sdata_rep;
                        w_cnt_nxt    = 8'd0;
                        w_op_nxt     = mem_op_i;
                        w_off_nxt    = mem_addr_i[1:0];
                        w_hwaddr_nxt = mem_waddr_i;
                        w_hwe_nxt    = mem_we_i;
                    end
                end
            end
            ST_BUSY: begin
                // An ack arriving on the timeout cycle still completes the transfer.
                if (dbus_ack_i) begin
                    w_state_nxt = ST_IDLE;
                    w_req_nxt   = 1'b0;
                    w_dwe_nxt   = 1'b0;
                    if (r_op <= OP_LW) begin
                        w_wb_wdata_nxt = w_load_data;
                        w_wb_waddr_nxt = r_hwaddr;
                        w_wb_we_nxt    = r_hwe;
                    end
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_req_nxt   = 1'b0;
                    w_dwe_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_dwe      <= 1'b0;
            r_daddr    <= 32'd0;
            r_be       <= 4'd0;
            r_dwdata   <= 32'd0;
            r_cnt      <= 8'd0;
            r_op       <= 4'd0;
            r_off      <= 2'd0;
            r_hwaddr   <= 5'd0;
            r_hwe      <= 1'b0;
            r_wb_wdata <= 32'd0;
            r_wb_waddr <= 5'd0;
            r_wb_we    <= 1'b0;
            r_misal    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= w_req_nxt;
            r_dwe      <= w_dwe_nxt;
            r_daddr    <= w_daddr_nxt;
            r_be       <= w_be_nxt;
            r_dwdata   <= w_dwdata_nxt;
            r_cnt      <= w_cnt_nxt;
            r_op       <= w_op_nxt;
            r_off      <= w_off_nxt;
            r_hwaddr   <= w_hwaddr_nxt;
            r_hwe      <= w_hwe_nxt;
            r_wb_wdata <= w_wb_wdata_nxt;
            r_wb_waddr <= w_wb_waddr_nxt;
            r_wb_we    <= w_wb_we_nxt;
            r_misal    <= w_misal_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign stall_o      = (r_state == ST_BUSY);
    assign dbus_req_o   = r_req;
    assign dbus_we_o    = r_dwe;
    assign dbus_addr_o  = r_daddr;
    assign dbus_be_o    = r_be;
    assign dbus_wdata_o = r_dwdata;
    assign wb_wdata_o   = r_wb_wdata;
    assign wb_waddr_o   = r_wb_waddr;
    assign wb_we_o      = r_wb_we;
    assign misalign_o   = r_misal;
    assign bus_err_o    = r_err;
endmodule
